// File: rtl/byte_encode12_pkg.sv
// Shared constants, state encoding and the coefficient range helper for the
// ByteEncode12 packer.
package byte_encode12_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int BEAT_W  = 48;
    localparam int WORD_W  = 64;
    localparam int BUF_W   = 112;
    localparam int FILL_W  = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True when any of the four 12-bit coefficients in a beat is >= q.
    function automatic logic beat_out_of_range(input logic [BEAT_W-1:0] beat,
                                               input logic [11:0] q);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (beat[12*k +: 12] >= q) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/byte_encode12_gearbox.sv
// 48-to-64 bit gearbox: accumulates 48-bit beats in a 112-bit buffer and
// emits 64-bit words, with registered ready/valid on both sides.
module byte_encode12_gearbox
    import byte_encode12_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_run_next,
    input  logic              i_allow_next,
    input  logic              i_last_next,
    input  logic [BEAT_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_in_fire,
    output logic              o_out_fire
);

    logic [BUF_W-1:0]  buf_q;
    logic [BUF_W-1:0]  buf_shift;
    logic [BUF_W-1:0]  buf_n;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_shift;
    logic [FILL_W-1:0] fill_n;
    logic              valid_n;

    assign o_in_fire  = o_ready && i_valid;
    assign o_out_fire = o_valid && i_ready;

    // A word leaving in the same cycle moves the write offset down by 64,
    // so the incoming beat lands directly above the remaining bits.
    always_comb begin
        buf_shift  = o_out_fire ? (buf_q >> WORD_W) : buf_q;
        fill_shift = o_out_fire ? (fill_q - 7'd64) : fill_q;
        buf_n      = buf_shift;
        fill_n     = fill_shift;
        if (o_in_fire) begin
            buf_n  = buf_shift | ({{(BUF_W-BEAT_W){1'b0}}, i_data} << fill_shift);
            fill_n = fill_shift + 7'd48;
        end
        if (i_clear) begin
            buf_n  = '0;
            fill_n = '0;
        end
        valid_n = i_run_next && (fill_n >= 7'd64);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_q   <= '0;
            fill_q  <= '0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else begin
            buf_q   <= buf_n;
            fill_q  <= fill_n;
            o_ready <= i_run_next && i_allow_next && (fill_n <= 7'd64);
            o_valid <= valid_n;
            o_last  <= valid_n && i_last_next;
            o_data  <= valid_n ? buf_n[WORD_W-1:0] : '0;
        end
    end

endmodule

// File: rtl/byte_encode12.sv
// ByteEncode12 packer: frames 256 12-bit coefficients (4 per beat) into 48
// little-endian 64-bit words, with a sticky range flag and a done pulse.
module byte_encode12
    import byte_encode12_pkg::*;
#(
    parameter int N_COEFFS = KYBER_N,
    parameter int Q        = KYBER_Q
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BEAT_W-1:0] i_coeffs,
    input  logic              i_coeffs_valid,
    output logic              o_coeffs_ready,
    output logic [WORD_W-1:0] o_obytes,
    output logic              o_obytes_valid,
    input  logic              i_obytes_ready,
    output logic              o_obytes_last,
    output logic              o_done,
    output logic              o_range_err,
    output state_t            o_state
);

    localparam int BEATS = N_COEFFS / 4;
    localparam int WORDS = N_COEFFS * 12 / WORD_W;
    localparam int CIW   = $clog2(BEATS + 1);
    localparam int COW   = $clog2(WORDS + 1);
    localparam logic [CIW-1:0] BEATS_C   = CIW'(BEATS);
    localparam logic [COW-1:0] LAST_WORD = COW'(WORDS - 1);
    localparam logic [11:0]    Q_C       = 12'(Q);

    state_t         state;
    state_t         state_n;
    logic [CIW-1:0] cnt_in;
    logic [CIW-1:0] cnt_in_n;
    logic [COW-1:0] cnt_out;
    logic [COW-1:0] cnt_out_n;
    logic           start;
    logic           in_fire;
    logic           out_fire;

    assign o_state = state;

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        cnt_in_n  = cnt_in;
        cnt_out_n = cnt_out;
        case (state)
            S_IDLE: begin
                if (i_coeffs_valid) begin
                    state_n   = S_PACK;
                    start     = 1'b1;
                    cnt_in_n  = '0;
                    cnt_out_n = '0;
                end
            end
            S_PACK: begin
                if (in_fire) cnt_in_n = cnt_in + 1'b1;
                if (out_fire) begin
                    cnt_out_n = cnt_out + 1'b1;
                    if (cnt_out == LAST_WORD) state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    byte_encode12_gearbox u_gearbox (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (start),
        .i_run_next  (state_n == S_PACK),
        .i_allow_next(cnt_in_n < BEATS_C),
        .i_last_next (cnt_out_n == LAST_WORD),
        .i_data      (i_coeffs),
        .i_valid     (i_coeffs_valid),
        .o_ready     (o_coeffs_ready),
        .o_data      (o_obytes),
        .o_valid     (o_obytes_valid),
        .i_ready     (i_obytes_ready),
        .o_last      (o_obytes_last),
        .o_in_fire   (in_fire),
        .o_out_fire  (out_fire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt_in      <= '0;
            cnt_out     <= '0;
            o_done      <= 1'b0;
            o_range_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt_in  <= cnt_in_n;
            cnt_out <= cnt_out_n;
            o_done  <= (state_n == S_DONE);
            if (start) begin
                o_range_err <= 1'b0;
            end else if (in_fire && beat_out_of_range(i_coeffs, Q_C)) begin
                o_range_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_encode12.sv
// Randomised scoreboard bench for byte_encode12: a driver feeds coefficient
// frames, a reference model queues expected words, a monitor pops and compares.
module tb_byte_encode12;
    import byte_encode12_pkg::*;

    // Handshake: an item transfers on a rising edge where valid && ready; the
    // producer keeps valid and data stable until that edge.

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        i_rst;
    logic [47:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        o_coeffs_ready;
    logic [63:0] o_obytes;
    logic        o_obytes_valid;
    logic        i_obytes_ready;
    logic        o_obytes_last;
    logic        o_done;
    logic        o_range_err;
    state_t      o_state;

    always #5 clk = ~clk;

    byte_encode12 dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_coeffs      (i_coeffs),
        .i_coeffs_valid(i_coeffs_valid),
        .o_coeffs_ready(o_coeffs_ready),
        .o_obytes      (o_obytes),
        .o_obytes_valid(o_obytes_valid),
        .i_obytes_ready(i_obytes_ready),
        .o_obytes_last (o_obytes_last),
        .o_done        (o_done),
        .o_range_err   (o_range_err),
        .o_state       (o_state)
    );

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];
    logic [11:0] frame_c [256];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    int          rdy_pct = 100;
    bit          exp_done = 1'b0;
    int          word_idx = 0;
    logic [63:0] first_word = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stream bytes from coefficient pairs, then 8 bytes per word.
    task automatic push_expected();
        logic [7:0]  bytes [384];
        logic [63:0] w;
        for (int i = 0; i < 128; i++) begin
            bytes[3*i]   = frame_c[2*i][7:0];
            bytes[3*i+1] = {frame_c[2*i+1][3:0], frame_c[2*i][11:8]};
            bytes[3*i+2] = frame_c[2*i+1][11:4];
        end
        for (int wi = 0; wi < 48; wi++) begin
            for (int b = 0; b < 8; b++) w[8*b +: 8] = bytes[8*wi + b];
            exp_q.push_back({(wi == 47), w});
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_frame(input int n_beats, input int gap_pct);
        logic [11:0] c [256];
        int  idx;
        int  guard;
        bit  holding;
        bit  err_model;
        c = frame_c;
        push_expected();
        idx = 0;
        guard = 0;
        holding = 1'b0;
        err_model = 1'b0;
        while (idx < n_beats && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (idx > 0) check("range_err_live", 64'(o_range_err), 64'(err_model));
            if (!holding) i_coeffs_valid = ($urandom_range(0, 99) >= gap_pct);
            i_coeffs = {c[4*idx+3], c[4*idx+2], c[4*idx+1], c[4*idx]};
            if (i_coeffs_valid && o_coeffs_ready) begin
                for (int k = 0; k < 4; k++)
                    if (c[4*idx+k] >= 12'd3329) err_model = 1'b1;
                idx++;
                holding = 1'b0;
            end else begin
                holding = i_coeffs_valid;
            end
        end
        if (idx < n_beats) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", idx, n_beats);
        end
        @(negedge clk);
        i_coeffs_valid = 1'b0;
        check("range_err_end", 64'(o_range_err), 64'(err_model));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [64:0] e;
        logic [63:0] held_data;
        bit          held_last;
        bit          prev_stall;
        bit          rdy;
        prev_stall = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        i_obytes_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                i_obytes_ready = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("done_pulse", 64'(o_done), 64'(exp_done));
                exp_done = 1'b0;
                if (!o_obytes_valid) check("last_without_valid", 64'(o_obytes_last), 64'd0);
                if (prev_stall) begin
                    check("stall_valid", 64'(o_obytes_valid), 64'd1);
                    check("stall_data", o_obytes, held_data);
                    check("stall_last", 64'(o_obytes_last), 64'(held_last));
                end
                rdy = ($urandom_range(0, 99) < rdy_pct);
                i_obytes_ready = rdy;
                if (o_obytes_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h with no word expected", o_obytes);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", o_obytes, e[63:0]);
                        check("word_last", 64'(o_obytes_last), 64'(e[64]));
                        if (word_idx == 0) first_word = o_obytes;
                        word_idx = e[64] ? 0 : word_idx + 1;
                        if (e[64]) exp_done = 1'b1;
                    end
                end
                prev_stall = o_obytes_valid && !rdy;
                held_data  = o_obytes;
                held_last  = o_obytes_last;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(o_coeffs_ready), 64'd0);
        check({tag, "_obytes"}, o_obytes, 64'd0);
        check({tag, "_valid"}, 64'(o_obytes_valid), 64'd0);
        check({tag, "_last"}, 64'(o_obytes_last), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
        check({tag, "_range_err"}, 64'(o_range_err), 64'd0);
        check({tag, "_state"}, 64'(o_state), 64'(S_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        i_rst = 1'b1;
        i_coeffs = '0;
        i_coeffs_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2;
        i_rst = 1'b0;
        mon_en = 1'b1;

        // Ascending coefficients, ready tied high.
        rdy_pct = 100;
        for (int i = 0; i < 256; i++) frame_c[i] = 12'(i + 1);
        send_frame(64, 0);
        wait_drain();
        check("seq_word0", first_word, 64'h6005_0040_0300_2001);

        // All 0xD00: repeating 00,0D,D0 byte pattern, in range.
        for (int i = 0; i < 256; i++) frame_c[i] = 12'hD00;
        send_frame(64, 0);
        wait_drain();
        check("d00_word0", first_word, 64'h0D00_D00D_00D0_0D00);
        check("d00_range_err", 64'(o_range_err), 64'd0);

        // Same ascending frame under random backpressure and input gaps.
        rdy_pct = 50;
        for (int i = 0; i < 256; i++) frame_c[i] = 12'(i + 1);
        send_frame(64, 30);
        wait_drain();
        check("seq_stall_word0", first_word, 64'h6005_0040_0300_2001);

        // Random in-range coefficients, random stalls.
        for (int i = 0; i < 256; i++) frame_c[i] = 12'($urandom_range(0, 3328));
        send_frame(64, 40);
        wait_drain();

        // Coefficient 37 = Q: flag rises the cycle after its beat, raw bits packed.
        rdy_pct = 100;
        for (int i = 0; i < 256; i++) frame_c[i] = 12'($urandom_range(0, 3328));
        frame_c[37] = 12'd3329;
        send_frame(64, 0);
        wait_drain();
        check("q_range_err_held", 64'(o_range_err), 64'd1);

        // Reset mid-frame after 20 beats, then a clean full frame.
        rdy_pct = 70;
        for (int i = 0; i < 256; i++) frame_c[i] = 12'($urandom_range(0, 4095));
        frame_c[3] = 12'd4000;
        send_frame(20, 0);
        repeat (10) @(negedge clk);
        #2 mon_en = 1'b0;
        @(negedge clk);
        #2;
        i_rst = 1'b1;
        exp_q.delete();
        word_idx = 0;
        exp_done = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        #2;
        i_rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 256; i++) frame_c[i] = 12'($urandom_range(0, 3328));
        send_frame(64, 20);
        wait_drain();

        // Back-to-back: out-of-range frame then in-range frame; flag must clear.
        rdy_pct = 100;
        for (int i = 0; i < 256; i++) frame_c[i] = 12'($urandom_range(0, 3328));
        frame_c[200] = 12'hFFF;
        send_frame(64, 0);
        for (int i = 0; i < 256; i++) frame_c[i] = 12'(255 - i);
        send_frame(64, 0);
        wait_drain();
        check("b2b_range_err", 64'(o_range_err), 64'd0);
        check("b2b_state", 64'(o_state), 64'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_encode12.md
# byte_encode12

Packs a polynomial of 256 12-bit Kyber coefficients into the 384-byte ByteEncode12 stream, emitted as 48 little-endian 64-bit words. It is the inverse-direction companion to the byte-to-coefficient parser. Coefficients arrive 4 per beat, the same 48-bit format the parser produces. Output words go to the hash/serialisation path (public key and ciphertext encoding). A 48→64-bit gearbox with valid/ready on both sides handles the width change.

## Interface
- `N_COEFFS`, 256: coefficients per frame; must be a multiple of 16.
- `Q`, 3329: modulus, used only for the range check.
- `i_clk`  in  1: clock, rising edge.
- `i_rst`  in  1: reset, synchronous, active-high; one clock, synchronous active-high reset.
- `i_coeffs`  in  48: 4 coefficients; coeff k in `[12k+11:12k]`, lowest index in `[11:0]`.
- `i_coeffs_valid`  in  1: input beat valid.
- `o_coeffs_ready`  out  1: block accepts the beat this cycle.
- `o_obytes`  out  64: output word; stream byte 8w+b in `[8b+7:8b]`.
- `o_obytes_valid`  out  1: output word valid.
- `i_obytes_ready`  in  1: downstream accepts the word.
- `o_obytes_last`  out  1: marks word `N_COEFFS*12/64-1` (word 47).
- `o_done`  out  1: one-cycle pulse after the last word is accepted.
- `o_range_err`  out  1: sticky flag; set when any accepted coefficient is ≥ Q.

## Operation
- Bit stream: coefficient j occupies stream bits `[12j+11:12j]`. Word w is stream bits `[64w+63:64w]`.
  - Byte 3i = `c[2i][7:0]`.
  - Byte 3i+1 = `{c[2i+1][3:0], c[2i][11:8]}`.
  - Byte 3i+2 = `c[2i+1][11:4]`.
- Storage:
  - Buffer register `buf[111:0]` with fill count `fill` (0..112, 7 bits).
  - Input-beat counter `cnt_in` (0..64).
  - Output-word counter `cnt_out` (0..48).
- FSM:
  - S_IDLE: `o_coeffs_ready`=0. Go to S_PACK when `i_coeffs_valid`=1. On this transition, clear `o_range_err`, `fill`, and both counters.
  - S_PACK:
    - `o_coeffs_ready` = (`fill` ≤ 64) && (`cnt_in` < 64).
    - `o_obytes_valid` = (`fill` ≥ 64).
    - Go to S_DONE when word 47 is accepted.
  - S_DONE: `o_done`=1 for one cycle, then go to S_IDLE.
- Buffer update per cycle:
  - Output accepted: shift `buf` right by 64 and subtract 64 from `fill`.
  - Input accepted: write the beat into `buf` at bit offset `fill` (or at `fill`−64 if an output is accepted in the same cycle), and add 48 to `fill`.
  - Both events may occur in the same cycle.
- Coefficients are packed unmodified. Values ≥ Q still pack their raw 12 bits and set `o_range_err`.
- Handshake:
  - A beat or word transfers when valid && ready.
  - Upstream holds `i_coeffs` stable while valid and not ready.
  - `o_obytes` and `o_obytes_last` stay stable while valid and not ready.
  - `i_coeffs_valid` while in S_DONE is ignored and not consumed.

## Timing
- Reset values: `o_coeffs_ready`=0, `o_obytes`=0, `o_obytes_valid`=0, `o_obytes_last`=0, `o_done`=0, `o_range_err`=0, state S_IDLE.
- Start: `i_coeffs_valid` rises at cycle t → S_PACK at t+1 → first beat accepted at t+1 (one-cycle bubble).
- First word: with back-to-back beats accepted at t+1 and t+2, `o_obytes_valid`=1 at t+3. All outputs are registered.
- Throughput with `i_obytes_ready`=1: 4 beats and 3 words every 6 cycles in steady state. The fill sequence 0,48,96,32,80,16,64,48… repeats.
- `o_obytes_last` is asserted only together with valid on word 47.
- `o_done` pulses in the cycle after word 47 is accepted. The next frame may start at that `o_done` cycle + 1.
- Boundaries:
  - `fill`=64 with an input accepted and no output accepted → `fill`=112, which is the maximum and never overflows.
  - `cnt_in`=64 blocks further input.
  - `i_rst` asserted mid-frame clears everything in the next cycle, with no partial `o_done`.

## Structure
- Shared constants go in `configs.v`:
  - `KYBER_Q` (3329), `KYBER_N` (256).
  - Derived beat/word counts (64, 48).
- One natural sub-module: `gearbox_48to64`, containing the buffer, fill count and the valid/ready core. The FSM, counters and range check live in `byte_encode12`.

## Test plan
- Coefficients 1,2,3,…,256 in order, ready tied high → word0 = 64'h6005_0040_0300_2001; 48 words total, `o_obytes_last` on word 47; `o_done` one cycle later.
- All coefficients 0xD00 (3328) → every word's bytes follow the repeating pattern 00,0D,D0; `o_range_err`=0.
- Random `i_obytes_ready` (50%) and random `i_coeffs_valid` gaps → same 48 words as the ready-high run; no drop or duplicate; outputs stable while stalled.
- Coefficient index 37 = 3329 → `o_range_err`=1 from the cycle after that beat until the next frame start; bits 0xD01 are packed unchanged.
- `i_rst` pulsed after 20 input beats → all outputs 0 next cycle; a following full frame produces the correct 48 words.
- Two frames back-to-back → second frame's word0 is correct; `o_range_err` is cleared at the second frame start.
